control_pipe: RTL and testbench
===============================

CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 Parameter ALU_OP_W, default 3: width of ex_alu_op.
REQ-002 Parameter EN_JUMP, default 1: 1 decodes JAL/JALR, 0 treats them as illegal.
REQ-003 Parameter LOAD_LAT, default 1, legal 1..3: bubbles inserted per load-use hazard.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 id_valid  in  1  decode-stage instruction present.
REQ-007 id_opcode  in  7  instruction[6:0].
REQ-008 id_rs1, id_rs2, id_rd  in  5 each  register specifiers.
REQ-009 flush  in  1  squash decode-stage instruction (branch taken).
REQ-010 stall  out  1  combinational, hold PC and IF/ID register.
REQ-011 ex_valid  out  1  ID/EX register holds a real instruction.
REQ-012 ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump  out  1 each  registered controls.
REQ-013 ex_alu_op  out  ALU_OP_W  registered ALU operation class.
REQ-014 ex_rd  out  5  registered destination.
REQ-015 illegal  out  1  registered one-cycle pulse, undecodable opcode accepted.
REQ-016 illegal_cnt  out  8  saturating count of illegal pulses.

Function
REQ-017 Decode {alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,jump,alu_op} SHALL be: 0110011 R={0,0,1,0,0,0,0,2}; 0010011 I={1,0,1,0,0,0,0,3}; 0000011 load={1,1,1,1,0,0,0,0}; 0100011 store={1,0,0,0,1,0,0,0}; 1100011 branch={0,0,0,0,0,1,0,1}; 1101111 JAL={1,0,1,0,0,0,1,0}; 1100111 JALR={1,0,1,0,0,0,1,0}; all others all-zero and illegal. No don't-care outputs.
REQ-018 alu_op values zero-extend to ALU_OP_W; ALU_OP_W below 2 is illegal.
REQ-019 Use flags: rs1 used by all legal opcodes except JAL; rs2 used only by R, store, branch.
REQ-020 Hazard = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((rs1 used & id_rs1==ex_rd) | (rs2 used & id_rs2==ex_rd)).
REQ-021 States RUN, STALL; 2-bit counter cnt.
REQ-022 RUN, no hazard: ID/EX loads decoded controls, ex_valid=id_valid & legal, ex_rd=id_rd; stall=0; latency 1 cycle.
REQ-023 RUN, hazard: stall=1, ID/EX loads bubble (ex_valid and all controls 0, ex_rd=0); if LOAD_LAT>1 go STALL with cnt=LOAD_LAT-1, else stay RUN.
REQ-024 STALL: stall=1, bubble loaded, cnt decrements; cnt==1 returns to RUN next cycle; total stall cycles equals LOAD_LAT.
REQ-025 STALL with id_valid=0: stall=0, bubble, return to RUN, cnt=0.
REQ-026 flush=1 (any state, priority over hazard and illegal): stall=0, bubble loaded, state RUN, cnt=0, no illegal pulse.
REQ-027 Illegal opcode with id_valid, no flush, no stall: bubble loaded, illegal=1 next cycle, illegal_cnt increments, saturates at 255.
REQ-028 Instruction held under stall SHALL NOT count as illegal until the cycle it is accepted.

Reset
REQ-029 rst_n low SHALL immediately clear state to RUN, cnt=0, ex_valid and all ex_* to 0, illegal=0, illegal_cnt=0; stall=0 while in reset.
REQ-030 Reset deassertion mid-STALL SHALL resume in RUN with no residual bubbles.

Verification
REQ-031 R-type add x3 (opcode 0110011, rd=3), id_valid=1 -> next cycle ex_valid=1, ex_reg_write=1, ex_alu_op=2, ex_rd=3.
REQ-032 Load rd=5 then R-type rs2=5, LOAD_LAT=1 -> stall=1 one cycle, one bubble, R-type enters EX on the following cycle.
REQ-033 Same as REQ-032 with LOAD_LAT=3 -> exactly 3 stall cycles and 3 bubbles; JAL after load rd=5 with id_rs1=5 -> no stall.
REQ-034 Load rd=0 then use of x0 -> no stall; flush asserted during STALL -> stall=0 same cycle, RUN next.
REQ-035 Opcode 1111111 accepted 300 times -> illegal pulses 300 times, illegal_cnt stops at 255; EN_JUMP=0 with 1101111 -> illegal=1, ex_valid=0.
REQ-036 rst_n asserted mid-STALL with outputs non-zero -> all outputs 0 without clock edge.

Source files
------------

// File: rtl/control_pipe.sv
// control_pipe
//   Decode-stage control unit with an ID/EX pipeline register. It decodes the
//   opcode into datapath controls, detects load-use hazards against the
//   instruction currently in EX, and inserts LOAD_LAT bubbles per hazard
//   while holding the front end. Undecodable opcodes become a bubble plus a
//   one-cycle illegal pulse and bump a saturating 8-bit counter.
//
// Parameters
//   ALU_OP_W  width of ex_alu_op (must be >= 2)
//   EN_JUMP   1: JAL/JALR decode normally, 0: they are illegal
//   LOAD_LAT  bubbles per load-use hazard, 1..3
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   id_valid, id_opcode            decode-stage instruction
//   id_rs1, id_rs2, id_rd          register specifiers
//   flush                          squash decode-stage instruction
//   stall                          (comb) hold PC and IF/ID
//   ex_valid, ex_* controls        ID/EX register contents
//   ex_alu_op, ex_rd               ALU class and destination in EX
//   illegal, illegal_cnt           illegal pulse and saturating count
module control_pipe #(
  parameter int ALU_OP_W = 3,
  parameter bit EN_JUMP  = 1'b1,
  parameter int LOAD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [6:0]          id_opcode,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic [4:0]          id_rd,
  input  logic                flush,
  output logic                stall,
  output logic                ex_valid,
  output logic                ex_alu_src,
  output logic                ex_mem_to_reg,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_branch,
  output logic                ex_jump,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [4:0]          ex_rd,
  output logic                illegal,
  output logic [7:0]          illegal_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_BR  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_R   = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_I   = ALU_OP_W'(3);

  // Remaining STALL-state cycles after the first hazard cycle spent in RUN.
  localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);

  typedef enum logic {RUN, STALL} state_e;

  typedef struct packed {
    logic                alu_src;
    logic                mem_to_reg;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                jump;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  ctrl_t       dec;
  logic        dec_legal;
  logic        use_rs1;
  logic        use_rs2;
  logic        hazard;
  logic        accept;
  ctrl_t       ex_ctrl_q, ex_ctrl_d;
  logic        ex_valid_q, ex_valid_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        illegal_q, illegal_d;
  logic [7:0]  illegal_cnt_q, illegal_cnt_d;

  // Opcode decode; unknown opcodes fall through to all-zero and illegal.
  always_comb begin
    dec       = '0;
    dec_legal = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (id_opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_R;
        dec_legal     = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_I: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_I;
        dec_legal     = 1'b1;
        use_rs1       = 1'b1;
      end
      OP_LOAD: begin
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_op     = ALU_ADD;
        dec_legal      = 1'b1;
        use_rs1        = 1'b1;
      end
      OP_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec_legal     = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_BR;
        dec_legal  = 1'b1;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        if (EN_JUMP) begin
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
          dec.jump      = 1'b1;
          dec.alu_op    = ALU_ADD;
          dec_legal     = 1'b1;
          // JAL has no source register; JALR reads rs1.
          use_rs1       = (id_opcode == OP_JALR);
        end
      end
      default: begin
        dec       = '0;
        dec_legal = 1'b0;
      end
    endcase
  end

  // Load in EX writing a register the decode-stage instruction reads.
  // Writes to x0 never create a dependency.
  assign hazard = id_valid && ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != 5'd0) &&
                  ((use_rs1 && (id_rs1 == ex_rd_q)) || (use_rs2 && (id_rs2 == ex_rd_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The hazard cycle itself is spent in RUN, so STALL only
  // covers the additional LOAD_LAT-1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = RUN;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard && (LOAD_LAT > 1)) begin
            state_d = STALL;
            cnt_d   = CNT_INIT;
          end
        end
        STALL: begin
          if (!id_valid || (cnt_q <= 2'd1)) begin
            state_d = RUN;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // Output logic: decides between loading decoded controls and a bubble.
  // An instruction held in STALL is never accepted, so it cannot raise
  // illegal until the cycle it actually moves on.
  always_comb begin
    stall     = 1'b0;
    accept    = 1'b0;
    illegal_d = 1'b0;
    if (!flush) begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            stall = 1'b1;
          end else if (id_valid && !dec_legal) begin
            illegal_d = 1'b1;
          end else begin
            accept = 1'b1;
          end
        end
        STALL: begin
          stall = id_valid;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
    ex_ctrl_d     = accept ? dec : '0;
    ex_valid_d    = accept && id_valid && dec_legal;
    ex_rd_d       = accept ? id_rd : 5'd0;
    illegal_cnt_d = (illegal_d && (illegal_cnt_q != 8'hFF)) ? illegal_cnt_q + 8'd1
                                                           : illegal_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q     <= '0;
      ex_valid_q    <= 1'b0;
      ex_rd_q       <= 5'd0;
      illegal_q     <= 1'b0;
      illegal_cnt_q <= 8'd0;
    end else begin
      ex_ctrl_q     <= ex_ctrl_d;
      ex_valid_q    <= ex_valid_d;
      ex_rd_q       <= ex_rd_d;
      illegal_q     <= illegal_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_alu_src    = ex_ctrl_q.alu_src;
  assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
  assign ex_reg_write  = ex_ctrl_q.reg_write;
  assign ex_mem_read   = ex_ctrl_q.mem_read;
  assign ex_mem_write  = ex_ctrl_q.mem_write;
  assign ex_branch     = ex_ctrl_q.branch;
  assign ex_jump       = ex_ctrl_q.jump;
  assign ex_alu_op     = ex_ctrl_q.alu_op;
  assign ex_rd         = ex_rd_q;
  assign illegal       = illegal_q;
  assign illegal_cnt   = illegal_cnt_q;

endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe
//   Drives three control_pipe instances from shared inputs:
//     dut 0: defaults (LOAD_LAT=1, EN_JUMP=1)
//     dut 1: LOAD_LAT=3
//     dut 2: EN_JUMP=0
//   Each instance is tracked by a reference model that counts outstanding
//   stall cycles per held instruction rather than modelling a state machine.
module tb_control_pipe;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n;
  logic idValid;
  logic [6:0] idOpcode;
  logic [4:0] idRs1, idRs2, idRd;
  logic flush;

  logic [2:0] stallV, exValidV, aluSrcV, memToRegV, regWriteV;
  logic [2:0] memReadV, memWriteV, branchV, jumpV, illegalV;
  logic [2:0][2:0] aluOpV;
  logic [2:0][4:0] exRdV;
  logic [2:0][7:0] illCntV;

  int compared = 0;
  int mismatched = 0;

  int latOf[3]     = '{1, 3, 1};
  bit enJumpOf[3]  = '{1'b1, 1'b1, 1'b0};

  // Model state: expected ID/EX contents plus outstanding stall cycles.
  bit       mExValid[3];
  bit [6:0] mCtl[3];   // {alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,jump}
  int       mAluOp[3];
  int       mRd[3];
  bit       mIll[3];
  int       mIllCnt[3];
  int       mStallLeft[3];

  bit lastStall[3];
  int stallCount[3];
  int bubbleCount[3];
  int illPulseCount[3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    control_pipe #(
      .ALU_OP_W(3),
      .EN_JUMP (g == 2 ? 1'b0 : 1'b1),
      .LOAD_LAT(g == 1 ? 3 : 1)
    ) u (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (idValid),
      .id_opcode    (idOpcode),
      .id_rs1       (idRs1),
      .id_rs2       (idRs2),
      .id_rd        (idRd),
      .flush        (flush),
      .stall        (stallV[g]),
      .ex_valid     (exValidV[g]),
      .ex_alu_src   (aluSrcV[g]),
      .ex_mem_to_reg(memToRegV[g]),
      .ex_reg_write (regWriteV[g]),
      .ex_mem_read  (memReadV[g]),
      .ex_mem_write (memWriteV[g]),
      .ex_branch    (branchV[g]),
      .ex_jump      (jumpV[g]),
      .ex_alu_op    (aluOpV[g]),
      .ex_rd        (exRdV[g]),
      .illegal      (illegalV[g]),
      .illegal_cnt  (illCntV[g])
    );
  end

  // Decode table taken straight from the instruction-class definitions.
  function automatic void refDecode(input logic [6:0] op, input bit enJump,
                                    output bit legal, output bit [6:0] ctl,
                                    output int aluOp, output bit u1, output bit u2);
    legal = 1'b0; ctl = 7'b0; aluOp = 0; u1 = 1'b0; u2 = 1'b0;
    case (op)
      OP_R:      begin legal = 1; ctl = 7'b0010000; aluOp = 2; u1 = 1; u2 = 1; end
      OP_I:      begin legal = 1; ctl = 7'b1010000; aluOp = 3; u1 = 1; end
      OP_LOAD:   begin legal = 1; ctl = 7'b1111000; aluOp = 0; u1 = 1; end
      OP_STORE:  begin legal = 1; ctl = 7'b1000100; aluOp = 0; u1 = 1; u2 = 1; end
      OP_BRANCH: begin legal = 1; ctl = 7'b0000010; aluOp = 1; u1 = 1; u2 = 1; end
      OP_JAL:    if (enJump) begin legal = 1; ctl = 7'b1010001; aluOp = 0; end
      OP_JALR:   if (enJump) begin legal = 1; ctl = 7'b1010001; aluOp = 0; u1 = 1; end
      default:   legal = 1'b0;
    endcase
  endfunction

  function automatic bit loadUseHazard(int i, bit u1, bit u2);
    return idValid && mExValid[i] && mCtl[i][3] && (mRd[i] != 0) &&
           ((u1 && (int'(idRs1) == mRd[i])) || (u2 && (int'(idRs2) == mRd[i])));
  endfunction

  function automatic bit modelStall(int i);
    bit legal, u1, u2;
    bit [6:0] ctl;
    int aop;
    refDecode(idOpcode, enJumpOf[i], legal, ctl, aop, u1, u2);
    if (flush) return 1'b0;
    if (mStallLeft[i] > 0) return idValid;
    return loadUseHazard(i, u1, u2);
  endfunction

  function automatic void modelStep(int i);
    bit legal, u1, u2;
    bit [6:0] ctl;
    int aop;
    bit load;
    refDecode(idOpcode, enJumpOf[i], legal, ctl, aop, u1, u2);
    load = 1'b0;
    mIll[i] = 1'b0;
    if (flush) begin
      mStallLeft[i] = 0;
    end else if (mStallLeft[i] > 0) begin
      mStallLeft[i] = idValid ? mStallLeft[i] - 1 : 0;
    end else if (loadUseHazard(i, u1, u2)) begin
      mStallLeft[i] = latOf[i] - 1;
    end else if (idValid && !legal) begin
      mIll[i] = 1'b1;
    end else begin
      load = 1'b1;
    end
    mExValid[i] = load && idValid && legal;
    mCtl[i]     = load ? ctl : 7'b0;
    mAluOp[i]   = load ? aop : 0;
    mRd[i]      = load ? int'(idRd) : 0;
    if (mIll[i] && mIllCnt[i] < 255) mIllCnt[i]++;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 3; i++) begin
      mExValid[i] = 0; mCtl[i] = 0; mAluOp[i] = 0; mRd[i] = 0;
      mIll[i] = 0; mIllCnt[i] = 0; mStallLeft[i] = 0;
    end
  endfunction

  task automatic checkOutput(string tag, int inst, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s dut%0d observed=%0h expected=%0h", tag, inst, obs, exp);
    end
  endtask

  task automatic checkDut(int i);
    checkOutput("ex_valid",      i, 32'(exValidV[i]),  32'(mExValid[i]));
    checkOutput("ex_alu_src",    i, 32'(aluSrcV[i]),   32'(mCtl[i][6]));
    checkOutput("ex_mem_to_reg", i, 32'(memToRegV[i]), 32'(mCtl[i][5]));
    checkOutput("ex_reg_write",  i, 32'(regWriteV[i]), 32'(mCtl[i][4]));
    checkOutput("ex_mem_read",   i, 32'(memReadV[i]),  32'(mCtl[i][3]));
    checkOutput("ex_mem_write",  i, 32'(memWriteV[i]), 32'(mCtl[i][2]));
    checkOutput("ex_branch",     i, 32'(branchV[i]),   32'(mCtl[i][1]));
    checkOutput("ex_jump",       i, 32'(jumpV[i]),     32'(mCtl[i][0]));
    checkOutput("ex_alu_op",     i, 32'(aluOpV[i]),    32'(mAluOp[i]));
    checkOutput("ex_rd",         i, 32'(exRdV[i]),     32'(mRd[i]));
    checkOutput("illegal",       i, 32'(illegalV[i]),  32'(mIll[i]));
    checkOutput("illegal_cnt",   i, 32'(illCntV[i]),   32'(mIllCnt[i]));
  endtask

  task automatic checkAllZero(string tag);
    for (int i = 0; i < 3; i++) begin
      checkOutput({tag, "_stall"}, i, 32'(stallV[i]), 32'd0);
      checkOutput({tag, "_ctl"}, i,
                  32'({exValidV[i], aluSrcV[i], memToRegV[i], regWriteV[i], memReadV[i],
                       memWriteV[i], branchV[i], jumpV[i], illegalV[i]}), 32'd0);
      checkOutput({tag, "_alu_op"}, i, 32'(aluOpV[i]), 32'd0);
      checkOutput({tag, "_rd"}, i, 32'(exRdV[i]), 32'd0);
      checkOutput({tag, "_ill_cnt"}, i, 32'(illCntV[i]), 32'd0);
    end
  endtask

  task automatic clearCounts();
    for (int i = 0; i < 3; i++) begin
      stallCount[i] = 0; bubbleCount[i] = 0; illPulseCount[i] = 0;
    end
  endtask

  // One clock cycle: drive inputs with clock low, check comb stall, advance
  // the model, then check registered outputs just after the rising edge.
  task automatic applyStimulus(logic v, logic [6:0] op, logic [4:0] r1, logic [4:0] r2,
                               logic [4:0] rd, logic fl);
    idValid = v; idOpcode = op; idRs1 = r1; idRs2 = r2; idRd = rd; flush = fl;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall", i, 32'(stallV[i]), 32'(modelStall(i)));
      lastStall[i] = stallV[i];
      if (stallV[i]) stallCount[i]++;
    end
    for (int i = 0; i < 3; i++) modelStep(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkDut(i);
      if (!exValidV[i]) bubbleCount[i]++;
      if (illegalV[i]) illPulseCount[i]++;
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rst_n = 1'b0; idValid = 1'b1; idOpcode = OP_R; idRs1 = 5'd1; idRs2 = 5'd2;
    idRd = 5'd3; flush = 1'b0;
    modelReset();
    clearCounts();
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // R-type add x3.
    applyStimulus(1, OP_R, 5'd1, 5'd2, 5'd3, 0);
    checkOutput("radd_valid", 0, 32'(exValidV[0]), 32'd1);
    checkOutput("radd_regw", 0, 32'(regWriteV[0]), 32'd1);
    checkOutput("radd_aluop", 0, 32'(aluOpV[0]), 32'd2);
    checkOutput("radd_rd", 0, 32'(exRdV[0]), 32'd3);

    // Load x5 then R-type reading x5 through rs2, held for four cycles.
    applyStimulus(1, OP_LOAD, 5'd1, 5'd0, 5'd5, 0);
    clearCounts();
    repeat (4) applyStimulus(1, OP_R, 5'd1, 5'd5, 5'd6, 0);
    checkOutput("lu_stalls_lat1", 0, 32'(stallCount[0]), 32'd1);
    checkOutput("lu_bubbles_lat1", 0, 32'(bubbleCount[0]), 32'd1);
    checkOutput("lu_stalls_lat3", 1, 32'(stallCount[1]), 32'd3);
    checkOutput("lu_bubbles_lat3", 1, 32'(bubbleCount[1]), 32'd3);
    checkOutput("lu_accept_lat3", 1, 32'({exValidV[1], exRdV[1]}), 32'({1'b1, 5'd6}));

    // JAL after load x5 with rs1=x5: JAL reads no register.
    applyStimulus(1, OP_LOAD, 5'd1, 5'd0, 5'd5, 0);
    applyStimulus(1, OP_JAL, 5'd5, 5'd5, 5'd1, 0);
    for (int i = 0; i < 3; i++) checkOutput("jal_no_stall", i, 32'(lastStall[i]), 32'd0);
    checkOutput("jal_jump", 1, 32'(jumpV[1]), 32'd1);
    checkOutput("nojump_illegal", 2, 32'(illegalV[2]), 32'd1);
    checkOutput("nojump_valid", 2, 32'(exValidV[2]), 32'd0);

    // Load to x0 then use of x0.
    applyStimulus(1, OP_LOAD, 5'd1, 5'd0, 5'd0, 0);
    applyStimulus(1, OP_R, 5'd0, 5'd0, 5'd7, 0);
    for (int i = 0; i < 3; i++) checkOutput("x0_no_stall", i, 32'(lastStall[i]), 32'd0);

    // Flush while the LOAD_LAT=3 instance sits in its extra stall cycles.
    applyStimulus(1, OP_LOAD, 5'd1, 5'd0, 5'd5, 0);
    applyStimulus(1, OP_I, 5'd5, 5'd0, 5'd6, 0);
    checkOutput("pre_flush_stall", 1, 32'(lastStall[1]), 32'd1);
    applyStimulus(1, OP_I, 5'd5, 5'd0, 5'd6, 1);
    checkOutput("flush_stall", 1, 32'(lastStall[1]), 32'd0);
    applyStimulus(1, OP_I, 5'd5, 5'd0, 5'd6, 0);
    checkOutput("post_flush_run", 1, 32'({lastStall[1], exValidV[1]}), 32'b01);

    // Decode-stage goes empty during the extra stall cycles.
    applyStimulus(1, OP_LOAD, 5'd1, 5'd0, 5'd5, 0);
    applyStimulus(1, OP_STORE, 5'd2, 5'd5, 5'd0, 0);
    applyStimulus(0, OP_STORE, 5'd2, 5'd5, 5'd0, 0);
    checkOutput("idle_in_stall", 1, 32'(lastStall[1]), 32'd0);

    // Illegal opcode repeated past counter saturation.
    clearCounts();
    repeat (300) applyStimulus(1, OP_BAD, 5'($urandom), 5'($urandom), 5'($urandom), 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("ill_pulses", i, 32'(illPulseCount[i]), 32'd300);
      checkOutput("ill_sat", i, 32'(illCntV[i]), 32'd255);
    end

    // Asynchronous reset while the LOAD_LAT=3 instance is stalled.
    applyStimulus(1, OP_LOAD, 5'd1, 5'd0, 5'd5, 0);
    applyStimulus(1, OP_BRANCH, 5'd5, 5'd1, 5'd0, 0);
    #1;
    checkOutput("mid_stall", 1, 32'(stallV[1]), 32'(modelStall(1)));
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, OP_BRANCH, 5'd5, 5'd1, 5'd0, 0);
    checkOutput("resume_run", 1, 32'({lastStall[1], exValidV[1]}), 32'b01);

    // Randomized traffic with a small register pool to provoke hazards.
    for (int n = 0; n < 500; n++) begin
      logic [6:0] op;
      case ($urandom_range(0, 8))
        0: op = OP_R;
        1: op = OP_I;
        2, 3: op = OP_LOAD;
        4: op = OP_STORE;
        5: op = OP_BRANCH;
        6: op = OP_JAL;
        7: op = OP_JALR;
        default: op = 7'($urandom);
      endcase
      applyStimulus(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0, op,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
